// File: rtl/jt_sfg01_pkg.sv
// Shared definitions for the SFG-01 audio path.
//   JTSFG01_DW         default sample width per channel
//   JTSFG01_FRAME_BITS I2S frame length in bclk periods (left + right)
//   JTSFG01_FM_PERIOD  FM core sample period in clk cycles
//   stereo_t           packed stereo word, left channel in the upper half
package jt_sfg01_pkg;

  localparam int JTSFG01_DW         = 16;
  localparam int JTSFG01_FRAME_BITS = 2 * JTSFG01_DW;
  localparam int JTSFG01_FM_PERIOD  = 64;

  typedef struct packed {
    logic signed [JTSFG01_DW-1:0] left;
    logic signed [JTSFG01_DW-1:0] right;
  } stereo_t;

endpackage

// File: rtl/jt_sfg01_i2s_clkgen.sv
// I2S timing generator: bclk divider, bit counter and word select.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   bclk        bit clock, clk/(2*DIV)
//   lrck        word select, 0 = left, 1 = right (registered)
//   frame       registered one-clk pulse on the edge a new frame begins
//   fall        combinational: bclk goes 1->0 at the next clk edge
//   fstart      combinational: that fall also wraps the bit counter
module jt_sfg01_i2s_clkgen
  import jt_sfg01_pkg::*;
#(
  parameter int DW  = JTSFG01_DW,
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic lrck,
  output logic frame,
  output logic fall,
  output logic fstart
);

  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW   = $clog2(2 * DW);
  localparam logic [BW-1:0] LAST_BIT = BW'(2 * DW - 1);

  logic [DIVW-1:0] div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_nxt;
  logic            div_end;

  assign div_end = (div_cnt == DIVW'(DIV - 1));
  assign fall    = div_end && bclk;
  assign fstart  = fall && (bit_cnt == LAST_BIT);
  assign bit_nxt = fstart ? '0 : bit_cnt + BW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= LAST_BIT;
      lrck    <= 1'b1;
      frame   <= 1'b0;
    end else begin
      frame <= fstart;
      if (div_end) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DIVW'(1);
      end
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrck    <= (bit_nxt >= BW'(DW));
      end
    end
  end

endmodule

// File: rtl/jt_sfg01_i2s.sv
// Stereo Philips-I2S serializer for the SFG-01 FM core output.
// Optional feature macro: JTSFG01_I2S_MUTE_EN (adds the mute input).
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   xleft, xright   signed samples, valid while sample is high
//   sample          one-clk sample strobe
//   mute            soft mute, sampled at frame start (macro only)
//   bclk, lrck      I2S bit clock and word select
//   sdata           serial data, MSB first, one-bit I2S delay
//   frame           one-clk pulse at each frame start
//   underrun        frame started with no new sample (word repeated)
//   overrun         pending sample overwritten before use
module jt_sfg01_i2s
  import jt_sfg01_pkg::*;
#(
  parameter int DW  = JTSFG01_DW,
  parameter int DIV = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] xleft,
  input  logic [DW-1:0] xright,
  input  logic          sample,
`ifdef JTSFG01_I2S_MUTE_EN
  input  logic          mute,
`endif
  output logic          bclk,
  output logic          lrck,
  output logic          sdata,
  output logic          frame,
  output logic          underrun,
  output logic          overrun
);

  localparam int WW = 2 * DW;

  logic [WW-1:0] pending;
  logic [WW-1:0] active;
  logic [WW-1:0] shreg;
  logic [WW-1:0] in_word;
  logic [WW-1:0] next_active;
  logic          pend_v;
  logic          fall;
  logic          fstart;
  logic          mute_now;

  jt_sfg01_i2s_clkgen #(
    .DW  (DW),
    .DIV (DIV)
  ) u_clkgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .bclk   (bclk),
    .lrck   (lrck),
    .frame  (frame),
    .fall   (fall),
    .fstart (fstart)
  );

`ifdef JTSFG01_I2S_MUTE_EN
  assign mute_now = mute;
`else
  assign mute_now = 1'b0;
`endif

  assign in_word = {xleft, xright};

  // Word loaded at frame start: pending wins over a coincident strobe,
  // a coincident strobe wins over repeating the previous frame.
  always_comb begin
    next_active = active;
    if (pend_v)
      next_active = pending;
    else if (sample)
      next_active = in_word;
    if (mute_now)
      next_active = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_v   <= 1'b0;
      active   <= '0;
      shreg    <= '0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
      if (fstart) begin
        active <= next_active;
        shreg  <= next_active;
        if (!pend_v && !sample)
          underrun <= 1'b1;
        if (pend_v && !sample)
          pend_v <= 1'b0;
        if (pend_v && sample)
          pending <= in_word;
      end else if (sample) begin
        pending <= in_word;
        pend_v  <= 1'b1;
        overrun <= pend_v;
      end
      // The shift register MSB after the last shift is the previous
      // word's right LSB, which becomes bit 0 of the next frame.
      if (fall) begin
        sdata <= shreg[WW-1];
        if (!fstart)
          shreg <= {shreg[WW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_jt_sfg01_i2s.sv
module tb_jt_sfg01_i2s;
  import jt_sfg01_pkg::*;

  localparam int DW  = 16;
  localparam int DIV = 1;
  localparam int FP  = 4 * DW * DIV;
  localparam int NE  = 2 + FP * 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample = 1'b0;
  logic [DW-1:0] xleft = '0;
  logic [DW-1:0] xright = '0;
`ifdef JTSFG01_I2S_MUTE_EN
  logic          mute = 1'b0;
`endif
  logic bclk, lrck, sdata, frame, underrun, overrun;

  always #5 clk = ~clk;

  jt_sfg01_i2s #(
    .DW  (DW),
    .DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .xleft    (xleft),
    .xright   (xright),
    .sample   (sample),
`ifdef JTSFG01_I2S_MUTE_EN
    .mute     (mute),
`endif
    .bclk     (bclk),
    .lrck     (lrck),
    .sdata    (sdata),
    .frame    (frame),
    .underrun (underrun),
    .overrun  (overrun)
  );

  typedef struct packed {
    logic under;
    logic over;
  } flags_t;

  stereo_t wq[$];
  flags_t  fq[$];
  int      chk_cnt = 0;
  int      pass_cnt = 0;
  int      edge_n = 0;
  bit      mon_en = 1'b0;

  stereo_t m_pend = '0;
  stereo_t m_act = '0;
  bit      m_pv = 1'b0;

  always @(posedge clk) if (rst_n) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
  endtask

  function automatic bit is_fs(input int n);
    return (n >= 2) && ((n - 2) % FP == 0);
  endfunction

  // Reference: what happens at clk edge n given the strobe seen there.
  task automatic model(input int n, input bit s, input stereo_t w);
    flags_t  f;
    stereo_t ld;
    f = '0;
    if (is_fs(n)) begin
      if (m_pv) begin
        ld = m_pend;
        if (s) m_pend = w;
        else m_pv = 1'b0;
      end else if (s) begin
        ld = w;
      end else begin
        ld = m_act;
        f.under = 1'b1;
      end
      m_act = ld;
      wq.push_back(ld);
    end else if (s) begin
      f.over = m_pv;
      m_pend = w;
      m_pv   = 1'b1;
    end
    fq.push_back(f);
  endtask

  // Monitor: checks outputs produced by edge n, half a cycle later.
  logic [31:0] cur = '0;
  bit          have = 1'b0;
  logic        lr_exp = 1'b1;
  int          mn, mk;
  flags_t      mf;
  stereo_t     mw;

  always @(negedge clk) begin
    if (mon_en && edge_n >= 1) begin
      mn = edge_n;
      mf = '0;
      if (fq.size() == 0) check("flag_queue_empty", 32'd0, 32'd1);
      else mf = fq.pop_front();
      if (mf.under || underrun) check("underrun", {31'd0, underrun}, {31'd0, mf.under});
      if (mf.over || overrun) check("overrun", {31'd0, overrun}, {31'd0, mf.over});
      if (is_fs(mn) || frame) check("frame", {31'd0, frame}, {31'd0, is_fs(mn)});
      if (mn % 2 == 0) begin
        mk = ((mn - 2) / 2) % (2 * DW);
        lr_exp = (mk >= DW);
        check("bclk_low", {31'd0, bclk}, 32'd0);
        check("lrck", {31'd0, lrck}, {31'd0, lr_exp});
        if (mk == 0) begin
          if (have) begin
            cur[0] = sdata;
            if (wq.size() == 0) check("word_queue_empty", 32'd0, 32'd1);
            else begin
              mw = wq.pop_front();
              check("word", cur, mw);
            end
          end else begin
            check("sdata_first", {31'd0, sdata}, 32'd0);
          end
          have = 1'b1;
        end else begin
          cur[2*DW-mk] = sdata;
        end
      end else begin
        check("bclk_high", {31'd0, bclk}, 32'd1);
        check("lrck_hold", {31'd0, lrck}, {31'd0, lr_exp});
      end
    end
  end

  initial begin
    int      m, o;
    bit      s;
    stereo_t w;
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_bclk", {31'd0, bclk}, 32'd0);
    check("rst_lrck", {31'd0, lrck}, 32'd1);
    check("rst_sdata", {31'd0, sdata}, 32'd0);
    check("rst_frame", {31'd0, frame}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int n = 1; n <= NE; n++) begin
      s = 1'b0;
      w = '0;
      m = -1;
      o = 0;
      if (n >= 2) begin
        m = (n - 2) / FP;
        o = (n - 2) % FP;
      end
      if (m == 0 && o == 10) begin s = 1'b1; w = {16'hA5F0, 16'h0F0F}; end
      if (m == 3 && o == 5)  begin s = 1'b1; w = {16'h1111, 16'h2222}; end
      if (m == 3 && o == 20) begin s = 1'b1; w = {16'h3333, 16'h4444}; end
      if (m == 5 && o == 0)  begin s = 1'b1; w = {16'h7FFF, 16'h8000}; end
      if (m == 5 && o == 30) begin s = 1'b1; w = {16'h1357, 16'h9BDF}; end
      if (m == 6 && o == 0)  begin s = 1'b1; w = {16'hCAFE, 16'hBEEF}; end
      if (m >= 8 && $urandom_range(0, 39) == 0) begin
        s = 1'b1;
        w = $urandom();
      end
      sample = s;
      xleft  = w.left;
      xright = w.right;
      model(n, s, w);
      @(posedge clk);
      #2;
    end
    sample = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
